// File: rtl/axi4_lite_sram_slave.sv
// axi4_lite_sram_slave: AXI4-Lite word-addressed SRAM responder with independent read/write
// response delays, optionally stretched by an LFSR to stress master handshakes.
module axi4_lite_sram_slave #(
   parameter int MEM_WORDS_LOG2 = 12,
   parameter int READ_DELAY     = 1,
   parameter int WRITE_DELAY    = 1,
   parameter bit RAND_DELAY     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [31:0] AWADDR,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY
);
   localparam int AW = MEM_WORDS_LOG2;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   logic [31:0] mem [0:2**AW-1];
   logic [7:0]  lfsr_q, lfsr_d, extra, rd_dly, wr_dly;
   r_state_t    rs_q, rs_d;
   logic [7:0]  rcnt_q, rcnt_d;
   logic [31:0] raddr_q, raddr_d, r_addr;
   logic        arready_q, arready_d, rvalid_q, rvalid_d, r_sample, r_oob;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   w_state_t    ws_q, ws_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, c_addr, c_data;
   logic [3:0]  wstrb_q, wstrb_d, c_strb;
   logic        aw_got_q, aw_got_d, w_got_q, w_got_d, aw_hs, w_hs, commit, c_oob;
   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        unused_ok;
   assign unused_ok = ^{r_addr[1:0], c_addr[1:0]};
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   // x^8+x^6+x^5+x^4+1; the extra delay is sampled when a transaction enters its wait
   always_comb begin
      lfsr_d = RAND_DELAY ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
      extra  = RAND_DELAY ? {6'd0, lfsr_q[1:0]} : 8'd0;
      rd_dly = 8'(READ_DELAY) + extra;
      wr_dly = 8'(WRITE_DELAY) + extra;
   end
   always_comb begin
      rs_d     = rs_q;
      rcnt_d   = rcnt_q;
      raddr_d  = raddr_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      r_sample = 1'b0;
      r_addr   = raddr_q;
      if (rs_q == R_IDLE && ARVALID && arready_q) begin
         raddr_d  = ARADDR;
         r_addr   = ARADDR;
         rcnt_d   = rd_dly;
         r_sample = rd_dly == 8'd0;
         rs_d     = r_sample ? R_RESP : R_WAIT;
      end else if (rs_q == R_WAIT) begin
         rcnt_d = rcnt_q - 8'd1;
         if (rcnt_q <= 8'd1) begin
            r_sample = 1'b1;
            rs_d     = R_RESP;
         end
      end else if (rs_q == R_RESP && RREADY) begin
         rs_d     = R_IDLE;
         rvalid_d = 1'b0;
      end
      // reading the array before this edge's commit lands gives pre-write data on a same-word hazard
      r_oob = |r_addr[31:AW+2];
      if (r_sample) begin
         rvalid_d = 1'b1;
         rdata_d  = r_oob ? 32'h0 : mem[r_addr[AW+1:2]];
         rresp_d  = r_oob ? SLVERR : OKAY;
      end
      arready_d = rs_d == R_IDLE;
   end
   always_comb begin
      ws_d     = ws_q;
      wcnt_d   = wcnt_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      commit   = 1'b0;
      aw_hs    = AWVALID && awready_q;
      w_hs     = WVALID && wready_q;
      c_addr   = aw_got_q ? awaddr_q : AWADDR;
      c_data   = w_got_q ? wdata_q : WDATA;
      c_strb   = w_got_q ? wstrb_q : WSTRB;
      c_oob    = |c_addr[31:AW+2];
      if (ws_q == W_IDLE) begin
         if (aw_hs) begin
            aw_got_d = 1'b1;
            awaddr_d = AWADDR;
         end
         if (w_hs) begin
            w_got_d = 1'b1;
            wdata_d = WDATA;
            wstrb_d = WSTRB;
         end
         if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            wcnt_d = wr_dly;
            commit = wr_dly == 8'd0;
            ws_d   = commit ? W_RESP : W_WAIT;
         end
      end else if (ws_q == W_WAIT) begin
         wcnt_d = wcnt_q - 8'd1;
         if (wcnt_q <= 8'd1) begin
            commit = 1'b1;
            ws_d   = W_RESP;
         end
      end else if (ws_q == W_RESP && BREADY) begin
         ws_d     = W_IDLE;
         bvalid_d = 1'b0;
         aw_got_d = 1'b0;
         w_got_d  = 1'b0;
      end
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = c_oob ? SLVERR : OKAY;
      end
      awready_d = ws_d == W_IDLE && !aw_got_d;
      wready_d  = ws_d == W_IDLE && !w_got_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q    <= 8'hA5;
         rs_q      <= R_IDLE;
         rcnt_q    <= 8'd0;
         raddr_q   <= 32'h0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'h0;
         rresp_q   <= OKAY;
         ws_q      <= W_IDLE;
         wcnt_q    <= 8'd0;
         awaddr_q  <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
      end else begin
         lfsr_q    <= lfsr_d;
         rs_q      <= rs_d;
         rcnt_q    <= rcnt_d;
         raddr_q   <= raddr_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         ws_q      <= ws_d;
         wcnt_q    <= wcnt_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end
   always_ff @(posedge clk) begin
      if (commit && !c_oob)
         for (int i = 0; i < 4; i++)
            if (c_strb[i]) mem[c_addr[AW+1:2]][8*i +: 8] <= c_data[8*i +: 8];
   end
endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// tb_axi4_lite_sram_slave: scoreboard bench driving a fixed-delay instance (READ_DELAY=0)
// and a random-delay instance (RAND_DELAY=1) of the SRAM responder.
module tb_axi4_lite_sram_slave;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [1:0]  arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] araddr [2], awaddr [2], wdata [2], rdata [2];
   logic [3:0]  wstrb [2];
   logic [1:0]  rresp [2], bresp [2];
   logic [31:0] ref_mem [2][4096];
   logic [3:0]  ref_kn [2][4096];
   logic [31:0] got;
   int n_vec = 0;
   int n_err = 0;

   axi4_lite_sram_slave #(.MEM_WORDS_LOG2(12), .READ_DELAY(0), .WRITE_DELAY(1), .RAND_DELAY(1'b0)) u_det (
      .clk(clk), .rst(rst),
      .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
      .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
      .AWADDR(awaddr[0]), .AWVALID(awvalid[0]), .AWREADY(awready[0]),
      .WDATA(wdata[0]), .WSTRB(wstrb[0]), .WVALID(wvalid[0]), .WREADY(wready[0]),
      .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(bready[0]));

   axi4_lite_sram_slave #(.MEM_WORDS_LOG2(12), .READ_DELAY(1), .WRITE_DELAY(1), .RAND_DELAY(1'b1)) u_rnd (
      .clk(clk), .rst(rst),
      .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
      .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
      .AWADDR(awaddr[1]), .AWVALID(awvalid[1]), .AWREADY(awready[1]),
      .WDATA(wdata[1]), .WSTRB(wstrb[1]), .WVALID(wvalid[1]), .WREADY(wready[1]),
      .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(bready[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_at, input int w_at, input int bh);
      bit aw_p = 1'b1;
      bit w_p = 1'b1;
      bit ha, hw;
      int cyc = 0;
      int lat = 0;
      bit oob = |a[31:14];
      logic [1:0] er = oob ? 2'b10 : 2'b00;
      awaddr[k] = a;
      wdata[k]  = d;
      wstrb[k]  = s;
      while ((aw_p || w_p) && cyc < 50) begin
         awvalid[k] = aw_p && cyc >= aw_at;
         wvalid[k]  = w_p && cyc >= w_at;
         ha = awvalid[k] && awready[k];
         hw = wvalid[k] && wready[k];
         @(negedge clk);
         if (ha) aw_p = 1'b0;
         if (hw) w_p = 1'b0;
         cyc++;
      end
      awvalid[k] = 1'b0;
      wvalid[k]  = 1'b0;
      check("w_accept", {30'd0, aw_p, w_p}, 32'd0);
      while (!bvalid[k] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (k == 0) check("w_lat", lat, 1);
      else check("w_lat_range", {31'd0, lat >= 1 && lat <= 4}, 1);
      for (int i = 0; i < bh; i++) begin
         check("b_hold_valid", bvalid[k], 1);
         check("b_hold_resp", bresp[k], er);
         @(negedge clk);
      end
      check("bvalid", bvalid[k], 1);
      check("bresp", bresp[k], er);
      bready[k] = 1'b1;
      @(negedge clk);
      bready[k] = 1'b0;
      check("b_drop", bvalid[k], 0);
      if (!oob)
         for (int i = 0; i < 4; i++)
            if (s[i]) begin
               ref_mem[k][a[13:2]][8*i +: 8] = d[8*i +: 8];
               ref_kn[k][a[13:2]][i] = 1'b1;
            end
   endtask

   task automatic do_read(input int k, input logic [31:0] a, input int rh, output logic [31:0] obs);
      int w = 0;
      int lat = 1;
      bit oob = |a[31:14];
      logic [31:0] ed = oob ? 32'h0 : ref_mem[k][a[13:2]];
      bit kn = oob || ref_kn[k][a[13:2]] == 4'hF;
      logic [1:0] er = oob ? 2'b10 : 2'b00;
      while (!arready[k] && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ar_ready", arready[k], 1);
      araddr[k]  = a;
      arvalid[k] = 1'b1;
      @(negedge clk);
      arvalid[k] = 1'b0;
      while (!rvalid[k] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (k == 0) check("r_lat", lat, 1);
      else check("r_lat_range", {31'd0, lat >= 2 && lat <= 5}, 1);
      for (int i = 0; i < rh; i++) begin
         check("r_hold_valid", rvalid[k], 1);
         check("r_hold_arready", arready[k], 0);
         if (kn) check("r_hold_data", rdata[k], ed);
         @(negedge clk);
      end
      check("rresp", rresp[k], er);
      if (kn) check("rdata", rdata[k], ed);
      obs = rdata[k];
      rready[k] = 1'b1;
      @(negedge clk);
      rready[k] = 1'b0;
      check("r_drop", rvalid[k], 0);
      check("ar_b2b", arready[k], 1);
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] off = 32'($urandom_range(0, 15)) * 32'd4;
      return ($urandom_range(0, 9) == 0) ? 32'h1000_0000 + off : 32'h100 + off;
   endfunction

   task automatic stress(input int k, input int n);
      logic [31:0] o;
      for (int j = 0; j < n; j++) begin
         do_write(k, pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         do_read(k, pick_addr(), $urandom_range(0, 3), o);
      end
   endtask

   initial begin
      arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
      for (int k = 0; k < 2; k++) begin
         araddr[k] = 32'h0; awaddr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'h0;
         for (int i = 0; i < 4096; i++) begin
            ref_mem[k][i] = 32'h0;
            ref_kn[k][i]  = 4'h0;
         end
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_rvalid", rvalid[k], 0);
         check("rst_bvalid", bvalid[k], 0);
         check("rst_rdata", rdata[k], 0);
         check("rst_rresp", rresp[k], 0);
         check("rst_bresp", bresp[k], 0);
         check("rst_arready", arready[k], 0);
         check("rst_awready", awready[k], 0);
         check("rst_wready", wready[k], 0);
      end
      rst = 1'b0;
      @(negedge clk);
      do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(0, 32'h10, 0, got);
      check("t1_data", got, 32'hDEADBEEF);
      do_write(0, 32'h10, 32'h0000AB00, 4'b0010, 0, 0, 0);
      do_read(0, 32'h10, 0, got);
      check("t2_data", got, 32'hDEADABEF);
      do_write(0, 32'h20, 32'h12345678, 4'hF, 3, 0, 5);
      do_read(0, 32'h20, 0, got);
      check("t3_data", got, 32'h12345678);
      do_write(0, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 2, 1);
      do_read(0, 32'h20, 0, got);
      check("strb0_data", got, 32'h12345678);
      do_read(0, 32'h10, 4, got);
      check("t4_data", got, 32'hDEADABEF);
      do_read(0, 32'h0010_0000, 0, got);
      check("t5_oob_rdata", got, 32'h0);
      do_write(0, 32'h0, 32'hCAFEF00D, 4'hF, 1, 0, 0);
      do_write(0, 32'h0010_0000, 32'h11111111, 4'hF, 0, 1, 2);
      do_read(0, 32'h0, 1, got);
      check("t5_unchanged", got, 32'hCAFEF00D);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) do_write(k, 32'h100 + 32'(i) * 32'd4, $urandom, 4'hF, 0, 0, 0);
      stress(0, 150);
      stress(1, 500);
      araddr[1]  = 32'h104;
      arvalid[1] = 1'b1;
      awaddr[1]  = 32'h108;
      awvalid[1] = 1'b1;
      @(negedge clk);
      arvalid[1] = 1'b0;
      awvalid[1] = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_rvalid", rvalid[1], 0);
      check("mid_rst_bvalid", bvalid[1], 0);
      check("mid_rst_arready", arready[1], 0);
      check("mid_rst_awready", awready[1], 0);
      check("mid_rst_wready", wready[1], 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_arready", arready[1], 1);
      check("post_rst_awready", awready[1], 1);
      stress(1, 500);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
